// File: rtl/restador_flotante_secuencial.sv
// restador_flotante_secuencial
// Multi-cycle floating-point subtractor, s = a - b. The sign of b is inverted
// on capture, so the datapath is an adder of signed magnitudes. Alignment and
// normalisation shift one bit per clock. Rounding is truncation.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          request, sampled only while idle
//   a, b           operands {sign, exp, man}
//   s              registered result, held until the next done
//   busy           high in every state except idle
//   done           one-cycle pulse when s and exp_out are valid
//   exp_out        overflow flag for the result in s
module restador_flotante_secuencial #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   s,
  output logic                   busy,
  output logic                   done,
  output logic                   exp_out
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int DW = $clog2(MAN_W + 3);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] SAT_E   = EXP_W'(MAN_W + 2);

  typedef enum logic [2:0] {
    IDLE, LOAD, ALIGN, OPERATE, NORMALIZE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic [EXP_W-1:0]   ex_q, ex_d, ey_q, ey_d;
  logic [MAN_W:0]     mx_q, mx_d, my_q, my_d;
  logic [DW-1:0]      d_q, d_d;
  logic [MAN_W+1:0]   r_q, r_d;
  logic [W-1:0]       s_q, s_d;
  logic               ov_q, ov_d;

  // Operand decode: a zero exponent means the value is zero.
  logic [EXP_W-1:0]   ea, eb, diff;
  logic [MAN_W:0]     siga, sigb;
  logic               a_ge_b;

  assign ea   = a_q[W-2:MAN_W];
  assign eb   = b_q[W-2:MAN_W];
  assign siga = (ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
  assign sigb = (eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
  // Ties keep a as X; the difference is then zero either way.
  assign a_ge_b = (ea > eb) || ((ea == eb) && (siga >= sigb));
  assign diff   = a_ge_b ? (ea - eb) : (eb - ea);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      d_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      d_q     <= d_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    mx_d    = mx_q;
    my_d    = my_q;
    d_d     = d_q;
    r_d     = r_q;
    s_d     = s_q;
    ov_d    = ov_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = {~b[W-1], b[W-2:0]};
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (a_ge_b) begin
          sx_d = a_q[W-1]; ex_d = ea; mx_d = siga;
          sy_d = b_q[W-1]; ey_d = eb; my_d = sigb;
        end else begin
          sx_d = b_q[W-1]; ex_d = eb; mx_d = sigb;
          sy_d = a_q[W-1]; ey_d = ea; my_d = siga;
        end
        // Beyond MAN_W+2 shifts Y is already zero, so cap the shift count.
        d_d     = (diff > SAT_E) ? DW'(MAN_W + 2) : DW'(diff);
        state_d = (diff != '0) ? ALIGN : OPERATE;
      end

      ALIGN: begin
        my_d = my_q >> 1;
        ey_d = ey_q + 1'b1;
        d_d  = d_q - 1'b1;
        if (d_q == DW'(1)) state_d = OPERATE;
      end

      OPERATE: begin
        // X has the larger magnitude, so the difference never goes negative.
        if (sx_q == sy_q) r_d = {1'b0, mx_q} + {1'b0, my_q};
        else              r_d = {1'b0, mx_q} - {1'b0, my_q};
        state_d = NORMALIZE;
      end

      NORMALIZE: begin
        // Exponent bounds are checked before shifting, so E never wraps.
        if (r_q == '0) begin
          s_d = '0; ov_d = 1'b0; state_d = DONE;
        end else if (ex_q == EXP_MAX) begin
          s_d = {sx_q, EXP_MAX, {MAN_W{1'b0}}}; ov_d = 1'b1; state_d = DONE;
        end else if (ex_q == '0) begin
          s_d = '0; ov_d = 1'b0; state_d = DONE;
        end else if (r_q[MAN_W+1]) begin
          r_d  = r_q >> 1;
          ex_d = ex_q + 1'b1;
        end else if (!r_q[MAN_W]) begin
          r_d  = r_q << 1;
          ex_d = ex_q - 1'b1;
        end else begin
          s_d = {sx_q, ex_q, r_q[MAN_W-1:0]}; ov_d = 1'b0; state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s       = s_q;
  assign exp_out = ov_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_restador_flotante_secuencial.sv
module tb_restador_flotante_secuencial;

  localparam int EW = 8;
  localparam int M  = 23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] s;
  logic        busy, done, exp_out;

  int n_checks = 0;
  int n_fail   = 0;

  restador_flotante_secuencial #(.EXP_W(EW), .MAN_W(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .s(s), .busy(busy), .done(done), .exp_out(exp_out)
  );

  always #5 clk = ~clk;

  // Reference: real-number subtraction carried out with integers, truncating
  // alignment, then normalisation counted one shift at a time.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                output logic [31:0] rs, output logic rov,
                                output int rlat);
    int ea, eb, ex, ey, d, n, e;
    longint ma, mb, mx, my, r;
    bit sa, sb, sx, sy;
    sa = ia[31]; sb = !ib[31];
    ea = int'(ia[M+EW-1:M]); eb = int'(ib[M+EW-1:M]);
    ma = (ea == 0) ? 0 : ((longint'(1) << M) + longint'(ia[M-1:0]));
    mb = (eb == 0) ? 0 : ((longint'(1) << M) + longint'(ib[M-1:0]));
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
    end
    d = ex - ey;
    if (d > M + 2) d = M + 2;
    my = my >> d;
    r  = (sx == sy) ? mx + my : mx - my;
    e  = ex; n = 0; rov = 1'b0; rs = '0;
    forever begin
      if (r == 0) begin rs = '0; break; end
      if (e == (1 << EW) - 1) begin rs = {sx, EW'(e), {M{1'b0}}}; rov = 1'b1; break; end
      if (e == 0) begin rs = '0; break; end
      if (r >= (longint'(1) << (M + 1))) begin r = r / 2; e++; n++; end
      else if (r < (longint'(1) << M)) begin r = r * 2; e--; n++; end
      else begin rs = {sx, EW'(e), M'(r)}; break; end
    end
    rlat = 3 + d + n;
  endfunction

  // Issue one operation and wait for done. Optionally pulse start with junk
  // operands at cycle 'glitch' while the unit is busy.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input int glitch,
                        output logic [31:0] rs, output logic rov, output int lat,
                        output logic busy0);
    int k;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; busy0 = 1'b0; lat = -1; rs = 'x; rov = 1'bx;
    while (k < 200) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (done) begin lat = k; rs = s; rov = exp_out; break; end
      if (k == glitch) begin start = 1'b1; a = 32'h3F800000; b = 32'h0; end
      else start = 1'b0;
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no done within 200 cycles, a=%h b=%h", ia, ib);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++; if (s !== 32'h0)   begin n_fail++; $display("FAIL reset_s: got %h want 0", s); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (exp_out !== 1'b0) begin n_fail++; $display("FAIL reset_exp_out: got %b want 0", exp_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] ta[8], tb_[8], ts[8];
    logic        tov[8];
    int          tl[8];
    logic [31:0] rs; logic rov, b0; int lat;
    ta = '{32'h41010000, 32'h40FC0000, 32'h3F800000, 32'h00000000,
           32'h7F7FFFFF, 32'h3F800000, 32'h00C00000, 32'h3F800000};
    tb_ = '{32'h3E400000, 32'h40FC0000, 32'hBF800000, 32'h41000000,
           32'hFF7FFFFF, 32'h3F800000, 32'h00800000, 32'h00000000};
    ts = '{32'h40FC0000, 32'h00000000, 32'h40000000, 32'hC1000000,
           32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    tov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tl  = '{10, 3, 4, 28, 4, 3, 4, 28};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb_[i], -1, rs, rov, lat, b0);
      n_checks++; if (rs !== ts[i]) begin n_fail++; $display("FAIL dir%0d_s: got %h want %h", i, rs, ts[i]); end
      n_checks++; if (rov !== tov[i]) begin n_fail++; $display("FAIL dir%0d_exp_out: got %b want %b", i, rov, tov[i]); end
      n_checks++; if (lat != tl[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
      n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_after_start: got %b want 1", i, b0); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL dir%0d_done_pulse: done=%b busy=%b want 0 0", i, done, busy); end
      n_checks++; if (s !== ts[i]) begin n_fail++; $display("FAIL dir%0d_s_hold: got %h want %h", i, s, ts[i]); end
    end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] rs; logic rov, b0; int lat;
    run_op(32'h41010000, 32'h3E400000, 4, rs, rov, lat, b0);
    n_checks++; if (rs !== 32'h40FC0000) begin n_fail++; $display("FAIL busy_start_s: got %h want 40fc0000", rs); end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 10", lat); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rs; logic rov, b0; int lat; bit saw;
    @(negedge clk);
    a = 32'h41010000; b = 32'h3E400000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);     // now in ALIGN
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || s !== 32'h0)
      begin n_fail++; $display("FAIL mid_reset: busy=%b done=%b s=%h want 0 0 0", busy, done, s); end
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) saw = 1;
    end
    n_checks++; if (saw) begin n_fail++; $display("FAIL mid_reset_no_done: got done pulse want none"); end
    run_op(32'h41010000, 32'h3E400000, -1, rs, rov, lat, b0);
    n_checks++; if (rs !== 32'h40FC0000 || lat != 10)
      begin n_fail++; $display("FAIL after_reset_op: s=%h lat=%0d want 40fc0000 10", rs, lat); end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, rs, es; logic rov, eov, b0; int lat, el, ea, eb;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: ea = 0;
        1: ea = $urandom_range(248, 254);
        2: ea = $urandom_range(1, 6);
        default: ea = $urandom_range(1, 254);
      endcase
      case ($urandom_range(0, 3))
        0: eb = ea;
        1: eb = (ea + $urandom_range(0, 30)) % 255;
        2: eb = 0;
        default: eb = $urandom_range(1, 254);
      endcase
      ra = {1'($urandom), EW'(ea), M'($urandom)};
      rb = {1'($urandom), EW'(eb), M'($urandom)};
      if ($urandom_range(0, 5) == 0) rb = {!ra[31], ra[30:0]};
      if ($urandom_range(0, 7) == 0) rb = {ra[31], ra[30:4], 4'($urandom)};
      model(ra, rb, es, eov, el);
      run_op(ra, rb, -1, rs, rov, lat, b0);
      n_checks++; if (rs !== es) begin n_fail++; $display("FAIL rand%0d_s: a=%h b=%h got %h want %h", i, ra, rb, rs, es); end
      n_checks++; if (rov !== eov) begin n_fail++; $display("FAIL rand%0d_exp_out: a=%h b=%h got %b want %b", i, ra, rb, rov, eov); end
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand%0d_latency: a=%h b=%h got %0d want %0d", i, ra, rb, lat, el); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_while_busy;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/restador_flotante_secuencial.md
# restador_flotante_secuencial

Multi-cycle IEEE-754-style floating-point subtractor computing s = a − b. It is the inverse-operation companion to the combinational floating-point adder and uses the same exponent/mantissa parameterisation and overflow flag. Alignment and normalisation run one bit per clock, trading latency for area. A start/done handshake lets a controller or test sequencer issue one operation at a time.

## Interface
- EXP_W, 8, exponent width (bias = 2^(EXP_W−1) − 1)
- MAN_W, 23, stored mantissa width (hidden bit not stored)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  1+EXP_W+MAN_W  minuend {sign, exp, man}
- b  in  1+EXP_W+MAN_W  subtrahend
- s  out  1+EXP_W+MAN_W  registered result, held until next DONE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, s valid
- exp_out  out  1  overflow flag for the result in s, updated with s

## Operation
- States: IDLE, LOAD, ALIGN, OPERATE, NORMALIZE, DONE.
- IDLE: start=1 latches a and b with b's sign inverted, then goes to LOAD. start in any other state is ignored; operands are not re-sampled.
- Operand decode: exp=0 means the value is zero, with hidden bit 0 and mantissa ignored. Otherwise the significand is {1, man}, MAN_W+1 bits. No denormals, NaN or Inf inputs are supported; exp = all-ones is treated as an ordinary value.
- LOAD:
  - Order operands so that X has the larger magnitude, comparing exponent then significand.
  - d = exp_X − exp_Y, saturated to MAN_W+2.
  - Go to ALIGN if d>0, else OPERATE.
- ALIGN: each cycle shifts Y's significand right 1 bit, increments exp_Y and decrements d. Shifted-out bits are discarded (truncation). When d reaches 0, go to OPERATE.
- OPERATE:
  - If the signs are equal, R = X+Y, MAN_W+2 bits.
  - Otherwise R = X−Y, which is never negative.
  - Result sign = sign of X; exponent E = exp_X.
- NORMALIZE, one action per cycle:
  - R=0 → result +0 (sign forced 0); go to DONE.
  - R[MAN_W+1]=1 → R>>=1, E+=1 (the dropped bit is truncated).
  - R[MAN_W]=0 → R<<=1, E−=1.
  - Otherwise, R is normalised: write s = {sign, E, R[MAN_W−1:0]} and go to DONE.
- Exponent boundaries:
  - E reaching all-ones (255 for EXP_W=8) → s = {sign, all-ones, 0} (±Inf), exp_out=1.
  - E reaching 0 → s = +0, exp_out=0 (flush to zero).
- DONE: done=1 and busy=1 for one cycle, then IDLE. exp_out stays valid until the next DONE.
- Rounding is truncation toward zero throughout.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, s=0, done=0, busy=0, exp_out=0, internal registers cleared. A reset mid-operation aborts it with no done pulse.
- Edge 0 samples start=1. busy rises after edge 0.
- d = alignment shifts; n = normalise shifts, counting right-shifts.
- done is high in the cycle following edge 3+d+n. s and exp_out update on that same edge.
- Latency bounds:
  - Minimum: 3 edges (d=0, n=0).
  - Maximum: 3 + (MAN_W+2) + (MAN_W+1) edges.
- A new start is accepted in the cycle after DONE (IDLE). Back-to-back issue spacing = latency + 1.

## Test plan
- 8.0625 − 0.1875:
  - a=0x41010000, b=0x3E400000.
  - Expect s=0x40FC0000 (7.875), exp_out=0.
  - d=6, n=1, so done follows edge 10.
- Exact cancellation:
  - a=b=0x40FC0000.
  - Expect s=0x00000000, exp_out=0.
- Sign handling:
  - a=0x3F800000 (1.0), b=0xBF800000 (−1.0) → s=0x40000000 (2.0), with one right-shift normalise.
  - Zero minuend: a=0x00000000, b=0x41000000 → s=0xC1000000 (−8.0).
- Overflow:
  - a=0x7F7FFFFF, b=0xFF7FFFFF.
  - Expect s=0x7F800000, exp_out=1.
  - A following 1.0−1.0 operation clears exp_out to 0.
- Handshake and reset:
  - Pulse start again while busy: it is ignored and the result is unchanged.
  - Drop rst_n during ALIGN of the first case: busy=0, done=0 and s=0 immediately, with no done pulse.
  - A new start then completes normally.
